// File: rtl/project_period_counter_master.sv
// Master PWM time base: UP / DOWN / UP_DOWN period counter driving the slave sync/phase-load chain.
// Optional PERIOD_SHADOW_EN: the active period is a shadow register updated only at period boundaries.
module project_period_counter_master #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_compare_b,
  input  logic [1:0]       i_sync_sel,
  input  logic             i_sync_en,
  input  logic             i_sw_sync,
  output logic [WIDTH-1:0] o_count,
  output logic             o_dir,
  output logic             o_zero,
  output logic             o_period_match,
  output logic             o_sync,
  output logic             o_phase_en,
  output logic [WIDTH-1:0] o_period_active
);

  typedef enum logic [1:0] {ModeOff, ModeUp, ModeDown, ModeUpDown} mode_e;
  typedef enum logic [1:0] {SelZero, SelPeriod, SelCompUp, SelCompDown} sync_sel_e;

  mode_e            mode;
  sync_sel_e        sync_sel;
  logic             counting;
  logic [WIDTH-1:0] count_q, count_d, count_up, count_dn;
  logic             dir_q, dir_d;
  logic             zero_q, zero_d;
  logic             match_q, match_d;
  logic             sync_q, sync_d;
  logic             sw_hit, ev_hit;
  logic [WIDTH-1:0] period_active, period_next;

  assign mode     = mode_e'(i_mode);
  assign sync_sel = sync_sel_e'(i_sync_sel);
  assign counting = (mode != ModeOff);
  assign count_up = count_q + WIDTH'(1);
  assign count_dn = count_q - WIDTH'(1);

`ifdef PERIOD_SHADOW_EN
  logic [WIDTH-1:0] shadow_q;
  logic             shadow_load;

  assign shadow_load   = !i_en || (counting && (i_sw_sync || count_d == '0));
  assign period_active = shadow_q;
  assign period_next   = shadow_load ? i_period : shadow_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= period_next;
    end
  end
`else
  assign period_active = i_period;
  assign period_next   = i_period;
`endif

  // Reloads always take i_period: with shadowing it is the value being loaded into the shadow.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    sw_hit  = 1'b0;
    if (i_en && counting) begin
      if (i_sw_sync) begin
        sw_hit  = 1'b1;
        count_d = (mode == ModeDown) ? i_period : '0;
        dir_d   = (mode == ModeDown);
      end else begin
        case (mode)
          ModeUp: begin
            dir_d   = 1'b0;
            count_d = (count_q >= period_active) ? '0 : count_up;
          end
          ModeDown: begin
            dir_d   = 1'b1;
            count_d = (count_q == '0) ? i_period : count_dn;
          end
          ModeUpDown: begin
            if (period_active == '0) begin
              count_d = '0;
              dir_d   = 1'b0;
            end else if (count_q == '0 || (!dir_q && count_q < period_active)) begin
              count_d = count_up;
              dir_d   = (count_up == period_active);
            end else begin
              count_d = count_dn;
              dir_d   = (count_dn != '0);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Events are decoded from the next count so the pulse lines up with the event value on o_count.
  always_comb begin
    ev_hit = 1'b0;
    unique case (sync_sel)
      SelZero:     ev_hit = (count_d == '0);
      SelPeriod:   ev_hit = (count_d == period_next);
      SelCompUp:   ev_hit = (count_d == i_compare_b) && !dir_d;
      SelCompDown: ev_hit = (count_d == i_compare_b) && dir_d;
      default:     ev_hit = 1'b0;
    endcase
    sync_d  = i_en && counting && i_sync_en && (sw_hit || ev_hit);
    zero_d  = i_en ? (count_d == '0) : zero_q;
    match_d = i_en ? (count_d == period_next) : match_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
      dir_q   <= 1'b0;
      zero_q  <= 1'b1;
      match_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      zero_q  <= zero_d;
      match_q <= match_d;
      sync_q  <= sync_d;
    end
  end

  assign o_count         = count_q;
  assign o_dir           = dir_q;
  assign o_zero          = zero_q;
  assign o_period_match  = match_q;
  assign o_sync          = sync_q;
  assign o_phase_en      = sync_q;
  assign o_period_active = period_active;

endmodule

// File: tb/tb_project_period_counter_master.sv
// Self-checking bench for project_period_counter_master: vector table plus hand sequences,
// expectations queued when driven and compared one clock later.
module tb_project_period_counter_master;

  localparam logic [1:0] MOff = 2'b00, MUp = 2'b01, MDown = 2'b10, MUd = 2'b11;
  localparam logic [1:0] SZero = 2'b00, SPer = 2'b01, SCUp = 2'b10, SCDn = 2'b11;

  typedef struct {
    logic        rst, en;
    logic [1:0]  mode;
    logic [15:0] period, cmp;
    logic [1:0]  sel;
    logic        sync_en, sw;
    logic [15:0] e_count;
    logic        e_dir, e_sync, cm;
  } vec_t;

  typedef struct {
    logic [15:0] count;
    logic        dir, sync, zero, match, cm;
  } exp_t;

  logic        i_clk = 1'b0, i_reset = 1'b1, i_en = 1'b0, i_sync_en = 1'b1, i_sw_sync = 1'b0;
  logic [1:0]  i_mode = MOff, i_sync_sel = SZero;
  logic [15:0] i_period = '0, i_compare_b = '0;
  logic [15:0] o_count, o_period_active;
  logic        o_dir, o_zero, o_period_match, o_sync, o_phase_en;

  int   total = 0;
  int   passed = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 i_clk = ~i_clk;

  project_period_counter_master #(.WIDTH(16)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_en           (i_en),
    .i_mode         (i_mode),
    .i_period       (i_period),
    .i_compare_b    (i_compare_b),
    .i_sync_sel     (i_sync_sel),
    .i_sync_en      (i_sync_en),
    .i_sw_sync      (i_sw_sync),
    .o_count        (o_count),
    .o_dir          (o_dir),
    .o_zero         (o_zero),
    .o_period_match (o_period_match),
    .o_sync         (o_sync),
    .o_phase_en     (o_phase_en),
    .o_period_active(o_period_active)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  function automatic vec_t mk(input logic rst, input logic en, input logic [1:0] mode,
                              input logic [15:0] period, input logic [15:0] cmp,
                              input logic [1:0] sel, input logic sync_en, input logic sw,
                              input logic [15:0] e_count, input logic e_dir,
                              input logic e_sync, input logic cm);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.period = period; v.cmp = cmp; v.sel = sel;
    v.sync_en = sync_en; v.sw = sw; v.e_count = e_count; v.e_dir = e_dir; v.e_sync = e_sync;
    v.cm = cm;
    return v;
  endfunction

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    i_reset = v.rst; i_en = v.en; i_mode = v.mode; i_period = v.period;
    i_compare_b = v.cmp; i_sync_sel = v.sel; i_sync_en = v.sync_en; i_sw_sync = v.sw;
    e.count = v.e_count; e.dir = v.e_dir; e.sync = v.e_sync;
    e.zero = (v.e_count == 16'd0); e.match = (v.e_count == v.period); e.cm = v.cm;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    check("count", idx, 32'(o_count), 32'(e.count));
    check("dir", idx, 32'(o_dir), 32'(e.dir));
    check("sync", idx, 32'(o_sync), 32'(e.sync));
    check("phase_en", idx, 32'(o_phase_en), 32'(e.sync));
    check("zero", idx, 32'(o_zero), 32'(e.zero));
    if (e.cm) check("period_match", idx, 32'(o_period_match), 32'(e.match));
  endtask

  // Run in a plain counting mode with one expected count per cycle.
  task automatic run(input logic [1:0] mode, input logic [15:0] p, input logic [15:0] cmp,
                     input logic [1:0] sel, input logic [15:0] c, input logic d,
                     input logic s);
    vecs.push_back(mk(0, 1, mode, p, cmp, sel, 1, 0, c, d, s, 1));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_count", 0, 32'(o_count), 32'd0);
    check("rst_dir", 0, 32'(o_dir), 32'd0);
    check("rst_zero", 0, 32'(o_zero), 32'd1);
    check("rst_match", 0, 32'(o_period_match), 32'd0);
    check("rst_sync", 0, 32'(o_sync), 32'd0);
    check("rst_phase_en", 0, 32'(o_phase_en), 32'd0);

    // UP, P=4, ZERO
    vecs.push_back(mk(1, 0, MUp, 4, 0, SZero, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, MUp, 4, 0, SZero, 1, 0, 0, 0, 0, 1));
    run(MUp, 4, 0, SZero, 1, 0, 0); run(MUp, 4, 0, SZero, 2, 0, 0);
    run(MUp, 4, 0, SZero, 3, 0, 0); run(MUp, 4, 0, SZero, 4, 0, 0);
    run(MUp, 4, 0, SZero, 0, 0, 1); run(MUp, 4, 0, SZero, 1, 0, 0);

    // UP_DOWN, P=3, compare_b=2, COMP_B_DOWN
    vecs.push_back(mk(1, 0, MUd, 3, 2, SCDn, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, MUd, 3, 2, SCDn, 1, 0, 0, 0, 0, 1));
    run(MUd, 3, 2, SCDn, 1, 0, 0); run(MUd, 3, 2, SCDn, 2, 0, 0);
    run(MUd, 3, 2, SCDn, 3, 1, 0); run(MUd, 3, 2, SCDn, 2, 1, 1);
    run(MUd, 3, 2, SCDn, 1, 1, 0); run(MUd, 3, 2, SCDn, 0, 0, 0);
    run(MUd, 3, 2, SCDn, 1, 0, 0);

    // DOWN, P=5, software resync at count 2
    vecs.push_back(mk(1, 0, MDown, 5, 0, SZero, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, MDown, 5, 0, SZero, 1, 0, 0, 0, 0, 1));
    run(MDown, 5, 0, SZero, 5, 1, 0); run(MDown, 5, 0, SZero, 4, 1, 0);
    run(MDown, 5, 0, SZero, 3, 1, 0); run(MDown, 5, 0, SZero, 2, 1, 0);
    vecs.push_back(mk(0, 1, MDown, 5, 0, SZero, 1, 1, 5, 1, 1, 1));
    run(MDown, 5, 0, SZero, 4, 1, 0); run(MDown, 5, 0, SZero, 3, 1, 0);
    run(MDown, 5, 0, SZero, 2, 1, 0); run(MDown, 5, 0, SZero, 1, 1, 0);
    run(MDown, 5, 0, SZero, 0, 1, 1); run(MDown, 5, 0, SZero, 5, 1, 0);

    // UP, P=10 lowered to 3 at count 6
    vecs.push_back(mk(1, 0, MUp, 10, 0, SZero, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, MUp, 10, 0, SZero, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 6; i++)
      vecs.push_back(mk(0, 1, MUp, 10, 0, SZero, 1, 0, 16'(i), 0, 0, 0));
`ifdef PERIOD_SHADOW_EN
    for (int i = 7; i <= 10; i++)
      vecs.push_back(mk(0, 1, MUp, 3, 0, SZero, 1, 0, 16'(i), 0, 0, 0));
    vecs.push_back(mk(0, 1, MUp, 3, 0, SZero, 1, 0, 0, 0, 1, 0));
`else
    vecs.push_back(mk(0, 1, MUp, 3, 0, SZero, 1, 0, 0, 0, 1, 0));
`endif
    run(MUp, 3, 0, SZero, 1, 0, 0); run(MUp, 3, 0, SZero, 2, 0, 0);
    run(MUp, 3, 0, SZero, 3, 0, 0); run(MUp, 3, 0, SZero, 0, 0, 1);

    // Enable low for 3 cycles at count 2 (resync ignored), PERIOD sel, then reset mid-count
    vecs.push_back(mk(1, 0, MUp, 4, 0, SPer, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, MUp, 4, 0, SPer, 1, 0, 0, 0, 0, 1));
    run(MUp, 4, 0, SPer, 1, 0, 0); run(MUp, 4, 0, SPer, 2, 0, 0);
    vecs.push_back(mk(0, 0, MUp, 4, 0, SPer, 1, 0, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, MUp, 4, 0, SPer, 1, 1, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, MUp, 4, 0, SPer, 1, 0, 2, 0, 0, 1));
    run(MUp, 4, 0, SPer, 3, 0, 0); run(MUp, 4, 0, SPer, 4, 0, 1);
    vecs.push_back(mk(1, 1, MUp, 4, 0, SPer, 1, 0, 0, 0, 0, 0));

    // P=0 in UP_DOWN, ZERO sel; sync_en low masks the pulse
    vecs.push_back(mk(0, 0, MUd, 0, 0, SZero, 1, 0, 0, 0, 0, 0));
    run(MUd, 0, 0, SZero, 0, 0, 1); run(MUd, 0, 0, SZero, 0, 0, 1);
    vecs.push_back(mk(0, 1, MUd, 0, 0, SZero, 0, 0, 0, 0, 0, 1));

    foreach (vecs[i]) apply(vecs[i], i + 1);

    // Mode changes mid-run with COMP_B_UP at 3, and OFF holding count and dir
    apply(mk(1, 0, MUp, 6, 3, SCUp, 1, 0, 0, 0, 0, 0), 100);
    apply(mk(0, 0, MUp, 6, 3, SCUp, 1, 0, 0, 0, 0, 1), 101);
    apply(mk(0, 1, MUp, 6, 3, SCUp, 1, 0, 1, 0, 0, 1), 102);
    apply(mk(0, 1, MUp, 6, 3, SCUp, 1, 0, 2, 0, 0, 1), 103);
    apply(mk(0, 1, MUp, 6, 3, SCUp, 1, 0, 3, 0, 1, 1), 104);
    apply(mk(0, 1, MDown, 6, 3, SCUp, 1, 0, 2, 1, 0, 1), 105);
    apply(mk(0, 1, MOff, 6, 3, SCUp, 1, 1, 2, 1, 0, 1), 106);
    apply(mk(0, 1, MUd, 6, 3, SCUp, 1, 0, 1, 1, 0, 1), 107);
    check("period_active", 108, 32'(o_period_active), 32'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
